vga_sync_receiver: RTL and testbench

// Sink-side counterpart of the VGA output path. Samples hsync/vsync/RGB on the pixel

---
 rtl/vga_rx_pkg.sv | 27 ++
 rtl/vga_sync_receiver_sync_edge_detect.sv | 25 ++
 rtl/vga_sync_receiver.sv | 168 ++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared timing constants and state type for the VGA sync receiver.
package vga_rx_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL   = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned V_TOTAL   = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned H_ACT_LO  = H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned H_ACT_HI  = H_ACT_LO + H_ACTIVE_DEF - 1;
  localparam int unsigned V_ACT_LO  = V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned V_ACT_HI  = V_ACT_LO + V_ACTIVE_DEF - 1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} rx_state_t;

  function automatic logic in_window(input logic [9:0] c, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_receiver_sync_edge_detect.sv
// Input register for an active-low sync line plus a one-cycle falling-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic fall
);

  logic cur;
  logic prev;

  // Both stages clear on reset so a line already low at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= sync;
      prev <= cur;
    end
  end

  assign fall = prev & ~cur;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sink: locks to sync timing, recovers pixel coordinates/colour, flags violations.
// Optional frame checksum enabled by defining VGA_RX_CHECKSUM_EN.
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  output logic        locked,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [23:0] pixel_rgb,
  output logic        frame_start,
  output logic        timing_err,
  output logic [31:0] frame_sum,
  output logic        frame_sum_valid
);

  localparam logic [9:0] H_TOT  = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [9:0] V_TOT  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [9:0] H_LO   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_HI   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_HI   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic        hs_fall, vs_fall;
  logic [23:0] rgb_q;
  logic [9:0]  h_cnt, v_cnt, h_next, v_next;
  rx_state_t   state, state_n;
  logic [3:0]  good, good_n;
  logic        line_err, frame_err, viol;
  logic        start_n, err_n, valid_n;

  sync_edge_detect u_hs (.clk(clk), .rst(rst), .sync(hsync_in), .fall(hs_fall));
  sync_edge_detect u_vs (.clk(clk), .rst(rst), .sync(vsync_in), .fall(vs_fall));

  // h_next/v_next are the counts belonging to the sample now held in rgb_q,
  // which keeps pixel outputs exactly two cycles behind the input.
  always_comb begin
    h_next = hs_fall ? '0 : ((h_cnt == H_TOT) ? H_TOT : h_cnt + 10'd1);
    if (vs_fall)      v_next = '0;
    else if (hs_fall) v_next = (v_cnt == V_TOT) ? V_TOT : v_cnt + 10'd1;
    else              v_next = v_cnt;
  end

  assign line_err  = hs_fall && (h_cnt != H_LAST);
  assign frame_err = vs_fall && (v_cnt != V_LAST);
  assign viol      = line_err | frame_err;

  always_comb begin
    state_n = state;
    good_n  = good;
    start_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_n = MEASURE;
          good_n  = '0;
          start_n = 1'b1;
        end
      end
      MEASURE: begin
        if (viol) begin
          good_n = '0;
          err_n  = 1'b1;
        end else if (vs_fall) begin
          start_n = 1'b1;
          good_n  = good + 4'd1;
          if (good + 4'd1 == LOCK_N) state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) begin
          state_n = SEARCH;
          good_n  = '0;
          err_n   = 1'b1;
        end else if (vs_fall) begin
          start_n = 1'b1;
        end
      end
      default: begin
        state_n = SEARCH;
        good_n  = '0;
      end
    endcase
  end

  assign valid_n = (state_n == LOCKED) && in_window(h_next, H_LO, H_HI)
                   && in_window(v_next, V_LO, V_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      good        <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      rgb_q       <= '0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
    end else begin
      state       <= state_n;
      good        <= good_n;
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      rgb_q       <= {red_in, green_in, blue_in};
      frame_start <= start_n;
      timing_err  <= err_n;
      pixel_valid <= valid_n;
      if (valid_n) begin
        pixel_x   <= h_next - H_LO;
        pixel_y   <= v_next - V_LO;
        pixel_rgb <= rgb_q;
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc             <= '0;
      frame_sum       <= '0;
      frame_sum_valid <= 1'b0;
    end else begin
      frame_sum_valid <= 1'b0;
      if ((state == LOCKED) && vs_fall && !viol) begin
        frame_sum       <= acc;
        frame_sum_valid <= 1'b1;
        acc             <= '0;
      end else if (state_n != LOCKED) begin
        acc <= '0;
      end else if (valid_n) begin
        acc <= acc + {8'd0, rgb_q};
      end
    end
  end
`else
  assign frame_sum       = '0;
  assign frame_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced 16x9 raster per frame.
module tb_vga_sync_receiver;

  localparam int H_ACT = 8, H_FPX = 2, H_SYN = 3, H_BPX = 3;
  localparam int V_ACT = 4, V_FPX = 1, V_SYN = 2, V_BPX = 2;
  localparam int H_TOT = H_ACT + H_FPX + H_SYN + H_BPX;
  localparam int H_LO = H_SYN + H_BPX, H_HI = H_LO + H_ACT - 1;
  localparam int V_LO = V_SYN + V_BPX, V_HI = V_LO + V_ACT - 1;
  localparam int NF = 19;
`ifdef VGA_RX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync_in, vsync_in;
  logic [7:0]  red_in, green_in, blue_in;
  logic        locked, pixel_valid, frame_start, timing_err, frame_sum_valid;
  logic [9:0]  pixel_x, pixel_y;
  logic [23:0] pixel_rgb;
  logic [31:0] frame_sum;

  vga_sync_receiver #(
    .H_ACTIVE(H_ACT), .H_FP(H_FPX), .H_SYNC(H_SYN), .H_BP(H_BPX),
    .V_ACTIVE(V_ACT), .V_FP(V_FPX), .V_SYNC(V_SYN), .V_BP(V_BPX),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .locked(locked), .pixel_valid(pixel_valid), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_rgb(pixel_rgb), .frame_start(frame_start),
    .timing_err(timing_err), .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nl; int sl; int rl; int mode;
    int valid; int err; int start; int lk_mid; int lk_end; int sv;
  } row_t;

  row_t        tbl [NF];
  int          checks = 0, errors = 0;
  int          f_valid, f_err, f_start, f_sv;
  logic        prev_act;
  logic [9:0]  prev_x, prev_y;
  logic [23:0] prev_rgb;
  logic [31:0] exp_sum, last_sum;

  function automatic logic [23:0] pix(input int mode, input logic [9:0] x, input logic [9:0] y);
    logic [7:0] a, b;
    a = x[7:0];
    b = y[7:0];
    case (mode)
      0:       return 24'h0096FF;
      1:       return (x == 10'd0 && y == 10'd0) ? 24'hFFFFFF : 24'h000000;
      2:       return 24'h000001;
      default: return {a * 8'd17 + 8'd3, b * 8'd29 + 8'd5, a ^ b};
    endcase
  endfunction

  task automatic chk(input string name, input int fr, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s frame %0d: got %0d expected %0d", name, fr, got, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({locked, pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_start, timing_err,
         frame_sum, frame_sum_valid} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not all zero (locked=%b valid=%b x=%0d y=%0d rgb=%h fs=%b te=%b sum=%h sv=%b)",
               name, locked, pixel_valid, pixel_x, pixel_y, pixel_rgb, frame_start,
               timing_err, frame_sum, frame_sum_valid);
    end
  endtask

  // Drive one input cycle; outputs seen afterwards belong to the previous input cycle.
  task automatic cyc(input logic hs, input logic vs, input logic act,
                     input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb);
    hsync_in = hs;
    vsync_in = vs;
    {red_in, green_in, blue_in} = rgb;
    @(negedge clk);
    if (pixel_valid) begin
      f_valid++;
      checks++;
      if (!(prev_act && pixel_x == prev_x && pixel_y == prev_y && pixel_rgb == prev_rgb)) begin
        errors++;
        $display("FAIL pixel: got x=%0d y=%0d rgb=%h, expected active=%0b x=%0d y=%0d rgb=%h",
                 pixel_x, pixel_y, pixel_rgb, prev_act, prev_x, prev_y, prev_rgb);
      end
    end
    if (timing_err)  f_err++;
    if (frame_start) f_start++;
    if (frame_sum_valid) begin
      f_sv++;
      checks++;
      if (frame_sum !== exp_sum) begin
        errors++;
        $display("FAIL frame_sum: got %h expected %h", frame_sum, exp_sum);
      end
    end
    prev_act = act;
    prev_x   = x;
    prev_y   = y;
    prev_rgb = rgb;
  endtask

  task automatic run_frame(input int nl, input int sl, input int rl, input int mode,
                           output logic lk_mid, output logic [31:0] msum);
    msum   = '0;
    lk_mid = 1'b0;
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == sl) ? H_TOT - 1 : H_TOT;
      for (int h = 0; h < len; h++) begin
        logic        act;
        logic [9:0]  x, y;
        logic [23:0] rgb;
        act = (h >= H_LO) && (h <= H_HI) && (l >= V_LO) && (l <= V_HI);
        x   = 10'(h - H_LO);
        y   = 10'(l - V_LO);
        rgb = act ? pix(mode, x, y) : 24'h000000;
        if (act) msum = msum + {8'd0, rgb};
        if (l == 1 && h == 0) lk_mid = locked;
        if (l == rl && h == 0) begin
          #1 rst = 1'b1;
          #1 chk_zero("async_reset");
          #1 rst = 1'b0;
        end
        cyc(h >= H_SYN, l >= V_SYN, act, x, y, rgb);
      end
    end
  endtask

  initial begin
    logic        lkm;
    logic [31:0] msum;
    //         nl sl  rl mode valid err start lk_mid lk_end sv
    tbl[0]  = '{9, -1, -1, 0,  0, 0, 1, 0, 0, 0};
    tbl[1]  = '{9, -1, -1, 0,  0, 0, 1, 0, 0, 0};
    tbl[2]  = '{9, -1, -1, 0, 32, 0, 1, 1, 1, 0};
    tbl[3]  = '{9, -1, -1, 2, 32, 0, 1, 1, 1, 1};
    tbl[4]  = '{9,  5, -1, 3, 16, 1, 1, 1, 0, 1};
    tbl[5]  = '{9, -1, -1, 0,  0, 0, 1, 0, 0, 0};
    tbl[6]  = '{9, -1, -1, 0,  0, 0, 1, 0, 0, 0};
    tbl[7]  = '{9, -1, -1, 3, 32, 0, 1, 1, 1, 0};
    tbl[8]  = '{8, -1, -1, 2, 32, 0, 1, 1, 1, 1};
    tbl[9]  = '{9, -1, -1, 0,  0, 1, 0, 0, 0, 0};
    tbl[10] = '{9, -1, -1, 0,  0, 0, 1, 0, 0, 0};
    tbl[11] = '{9, -1, -1, 0,  0, 0, 1, 0, 0, 0};
    tbl[12] = '{9, -1, -1, 1, 32, 0, 1, 1, 1, 0};
    tbl[13] = '{9, -1,  5, 2,  8, 0, 1, 1, 0, 1};
    tbl[14] = '{9, -1, -1, 0,  0, 0, 1, 0, 0, 0};
    tbl[15] = '{9, -1, -1, 0,  0, 0, 1, 0, 0, 0};
    tbl[16] = '{9, -1, -1, 0, 32, 0, 1, 1, 1, 0};
    tbl[17] = '{9, -1, -1, 2, 32, 0, 1, 1, 1, 1};
    tbl[18] = '{9, -1, -1, 0, 32, 0, 1, 1, 1, 1};

    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    {red_in, green_in, blue_in} = 24'h0;
    prev_act = 1'b0; prev_x = '0; prev_y = '0; prev_rgb = '0;
    last_sum = '0; exp_sum = '0;
    f_valid = 0; f_err = 0; f_start = 0; f_sv = 0;

    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    repeat (4) cyc(1'b1, 1'b1, 1'b0, '0, '0, '0);
    chk("idle_no_start", -1, f_start + f_err, 0);

    for (int i = 0; i < NF; i++) begin
      f_valid = 0; f_err = 0; f_start = 0; f_sv = 0;
      exp_sum = last_sum;
      run_frame(tbl[i].nl, tbl[i].sl, tbl[i].rl, tbl[i].mode, lkm, msum);
      last_sum = msum;
      chk("valid_count", i, f_valid, tbl[i].valid);
      chk("timing_err_count", i, f_err, tbl[i].err);
      chk("frame_start_count", i, f_start, tbl[i].start);
      chk("locked_mid", i, int'(lkm), tbl[i].lk_mid);
      chk("locked_end", i, int'(locked), tbl[i].lk_end);
      chk("sum_valid_count", i, f_sv, tbl[i].sv * CK);
`ifndef VGA_RX_CHECKSUM_EN
      chk("frame_sum_zero", i, int'(frame_sum), 0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
